uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side byte buffer fed by the UART receiver: captures each byte on its
//   one-cycle done strobe and holds it in a circular FIFO. Presents bytes to the
//   consumer over a first-word-fall-through valid/ready interface. Reports fill
//   level, full/empty/almost-full, and a sticky overflow flag for lost bytes.
// PARAMETERS
//   DATA_WIDTH    8   byte width; matches receiver data output
//   DEPTH_LOG2    4   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (16); range 1..10
//   AFULL_THRESH  12  almost_full asserts when level >= AFULL_THRESH; range 1..DEPTH
// PORTS
//   clk           in   1             system clock, all logic on rising edge
//   rst           in   1             asynchronous reset, active-high
//   in_data       in   DATA_WIDTH    byte from receiver (rx_data)
//   in_valid      in   1             push strobe (rx_done); one cycle per byte
//   out_data      out  DATA_WIDTH    head-of-FIFO byte; 0 when empty
//   out_valid     out  1             FIFO not empty
//   out_ready     in   1             consumer accepts head when out_valid=1
//   level         out  DEPTH_LOG2+1  entries held, 0..DEPTH
//   empty         out  1             level == 0
//   full          out  1             level == DEPTH
//   almost_full   out  1             level >= AFULL_THRESH
//   overflow      out  1             sticky: a push met a full FIFO
//   clr_overflow  in   1             synchronous clear of overflow
// BEHAVIOUR
//   - Reset (async assert, sync release): wr_ptr=rd_ptr=0, level=0, overflow=0;
//     out_valid=0, out_data=0, empty=1, full=0, almost_full=0. Storage not reset.
//   - Pointers DEPTH_LOG2 bits, wrap DEPTH-1 -> 0 naturally; level is an
//     explicit DEPTH_LOG2+1 bit counter (no pointer-compare ambiguity).
//   - push = in_valid; pop = out_valid & out_ready. Each high cycle of in_valid
//     is one push; upstream guarantees single-cycle strobes.
//   - Latency: push at edge N -> out_valid=1, out_data=byte after edge N (FWFT);
//     level/flags are registered and update on the same edge.
//   - out_data = mem[rd_ptr] combinationally when !empty, else 0.
//   - Pop advances rd_ptr; next byte visible the following cycle.
//   - Empty + push + out_ready: push only (pop requires out_valid); level 0->1.
//   - Not full, push+pop same cycle: both performed, level unchanged.
//   - Full, push+pop same cycle: both performed, level stays DEPTH, no overflow.
//   - Full, push, no pop: see CONFIGURATION; overflow=1 from next cycle.
//   - clr_overflow clears overflow next edge; simultaneous overflow event and
//     clr_overflow -> overflow=1 (set wins).
//   - Reset mid-operation discards all contents immediately; out_valid drops
//     asynchronously with rst.
//   - out_ready while empty is ignored; no state change.
// CONFIGURATION
//   UART_RX_FIFO_OVERWRITE_EN
//   - Undefined (default): push into full FIFO without pop is dropped; contents,
//     pointers and level unchanged; overflow set.
//   - Defined: push into full FIFO without pop discards the oldest entry
//     (rd_ptr and wr_ptr both advance, new byte written), level stays DEPTH,
//     out_data shows the next-oldest byte next cycle; overflow set.
// TESTING
//   1 Reset: rst=1 mid-stream with level=5 -> level=0, empty=1, out_valid=0,
//     out_data=0, overflow=0 without waiting for a clock edge.
//   2 Order/wrap: push 0x00..0x27 (40 bytes) interleaved with pops, level never
//     >DEPTH -> bytes popped in exact order 0x00..0x27; pointers wrap twice.
//   3 Fill: 16 pushes, out_ready=0 -> level=16, full=1, almost_full=1 from level
//     12 on; then 16 pops -> empty=1, out_data=0.
//   4 Overflow (default): full with 0x10..0x1F, push 0xAA -> overflow=1, level=16,
//     pops return 0x10..0x1F; clr_overflow=1 -> overflow=0 next cycle.
//   5 Overwrite (macro defined): same as 4 -> overflow=1, pops return 0x11..0x1F,
//     0xAA.
//   6 Simultaneous: full, push 0x55 + pop same cycle -> level=16, overflow=0,
//     0x55 emerges last; clr_overflow coincident with overflow event -> stays 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer for a UART receiver.
//   Captures each received byte on its one-cycle done strobe into a circular FIFO.
//   It presents the bytes first-word-fall-through on a valid/ready interface.
//   It also reports the fill level, the empty/full/almost-full flags and a sticky
//   overflow flag.
//
// Optional feature macro: UART_RX_FIFO_OVERWRITE_EN
//   undefined : a push into a full FIFO with no pop in the same cycle is dropped
//   defined   : a push into a full FIFO with no pop in the same cycle evicts the oldest byte
//   Either way, overflow is set.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   in_data      in   byte from receiver
//   in_valid     in   push strobe, one cycle per byte
//   out_data     out  head byte, 0 when empty
//   out_valid    out  FIFO not empty
//   out_ready    in   consumer takes head when out_valid=1
//   level        out  entries held, 0..DEPTH
//   empty        out  level == 0
//   full         out  level == DEPTH
//   almost_full  out  level >= AFULL_THRESH
//   overflow     out  sticky: a push met a full FIFO
//   clr_overflow in   synchronous clear of overflow (set wins)
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LvlFull  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   LvlAfull = (DEPTH_LOG2 + 1)'(AFULL_THRESH);
  localparam logic [DEPTH_LOG2:0]   LvlOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = (DEPTH_LOG2)'(1);

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;

  logic w_push;
  logic w_pop;
  logic w_ovf_event;
  logic w_do_write;
  logic w_do_read;

  // Flags decode the registered level, so they change on the same edge as level.
  assign level       = r_level;
  assign empty       = (r_level == '0);
  assign full        = (r_level == LvlFull);
  assign almost_full = (r_level >= LvlAfull);
  assign out_valid   = ~empty;
  assign overflow    = r_overflow;
  assign out_data    = empty ? '0 : r_mem[r_rd_ptr];

  assign w_push      = in_valid;
  assign w_pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so only an unaccompanied push overflows.
  assign w_ovf_event = w_push & full & ~w_pop;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  // Overflowing push evicts the head: both pointers advance, level holds at DEPTH.
  assign w_do_write = w_push;
  assign w_do_read  = w_pop | w_ovf_event;
`else
  // Overflowing push is dropped; state is untouched apart from the overflow flag.
  assign w_do_write = w_push & (~full | w_pop);
  assign w_do_read  = w_pop;
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_write) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_do_read) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      if (w_do_write && !w_do_read) begin
        r_level <= r_level + LvlOne;
      end else if (w_do_read && !w_do_write) begin
        r_level <= r_level - LvlOne;
      end
      if (w_ovf_event) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue-based model predicts the FIFO.
// A negedge compare process checks every output against it.
// Directed phases pin the model with literal expectations.
// Random traffic then follows.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       clr_overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          run_cmp  = 1'b0;

  logic [7:0] m_q[$];
  logic [7:0] m_popped[$];
  bit         m_ovf;

  uart_rx_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH_LOG2  (4),
    .AFULL_THRESH(12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of held bytes plus the sticky flag.
  always @(posedge clk or posedge rst) begin
    bit push, pop, ev;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      push = (in_valid === 1'b1);
      pop  = (m_q.size() != 0) && (out_ready === 1'b1);
      ev   = push && (m_q.size() == 16) && !pop;
      if (ev) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
        void'(m_q.pop_front());
        m_q.push_back(in_data);
`endif
      end else begin
        if (pop) m_popped.push_back(m_q.pop_front());
        if (push) m_q.push_back(in_data);
      end
      if (ev) m_ovf = 1'b1;
      else if (clr_overflow === 1'b1) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      int sz;
      sz = m_q.size();
      chk("cmp_level", 32'(level), 32'(sz));
      chk("cmp_empty", 32'(empty), 32'(sz == 0));
      chk("cmp_full", 32'(full), 32'(sz == 16));
      chk("cmp_afull", 32'(almost_full), 32'(sz >= 12));
      chk("cmp_valid", 32'(out_valid), 32'(sz != 0));
      chk("cmp_data", 32'(out_data), (sz != 0) ? 32'(m_q[0]) : 32'd0);
      chk("cmp_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  // Drive one cycle's inputs just after an edge, then advance to the next.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    in_valid     = v;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) cyc(1'b1, base + 8'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    int sent;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    #12;
    run_cmp = 1'b1;
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Test 1: async reset mid-stream with level 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("t1_level5", 32'(level), 32'd5);
    chk("t1_head", 32'(out_data), 32'h30);
    rst = 1'b1;
    #1;
    chk("t1_async_level", 32'(level), 32'd0);
    chk("t1_async_empty", 32'(empty), 32'd1);
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_data", 32'(out_data), 32'd0);
    chk("t1_async_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Test 2: 40 bytes through with random pops, wrapping the pointers twice.
    m_popped.delete();
    sent = 0;
    for (int c = 0; c < 2000 && (sent < 40 || m_q.size() != 0); c++) begin
      logic v;
      v = (sent < 40) && (m_q.size() < 16) && ($urandom_range(0, 1) == 1);
      cyc(v, 8'(sent), ($urandom_range(0, 2) != 0), 1'b0);
      if (v) sent++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk("t2_count", 32'(m_popped.size()), 32'd40);
    for (int i = 0; i < 40 && i < m_popped.size(); i++) chk("t2_order", 32'(m_popped[i]), 32'(i));

    // Test 3: fill to full, almost_full from level 12 on, then drain.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      chk("t3_afull", 32'(almost_full), 32'(i + 1 >= 12));
    end
    in_valid = 1'b0;
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_full", 32'(full), 32'd1);
    drain();
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_data0", 32'(out_data), 32'd0);

    // Test 4/5: overflow on a full FIFO.
    m_popped.delete();
    fill(8'h10);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_level", 32'(level), 32'd16);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    chk("t5_head", 32'(out_data), 32'h11);
`else
    chk("t4_head", 32'(out_data), 32'h10);
`endif
    drain();
    chk("t4_count", 32'(m_popped.size()), 32'd16);
    for (int i = 0; i < 16 && i < m_popped.size(); i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
      exp_b = (i == 15) ? 8'hAA : 8'h11 + 8'(i);
`else
      exp_b = 8'h10 + 8'(i);
`endif
      chk("t4_pop", 32'(m_popped[i]), 32'(exp_b));
    end
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    clr_overflow = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // Test 6: full with push+pop together, then clear coincident with overflow.
    m_popped.delete();
    fill(8'h60);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t6_level", 32'(level), 32'd16);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_head", 32'(out_data), 32'h61);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    in_valid = 1'b0; clr_overflow = 1'b0;
    chk("t6_set_wins", 32'(overflow), 32'd1);
    drain();
    chk("t6_count", 32'(m_popped.size()), 32'd17);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    if (m_popped.size() == 17) chk("t6_last", 32'(m_popped[16]), 32'h77);
    if (m_popped.size() == 17) chk("t6_55", 32'(m_popped[15]), 32'h55);
`else
    if (m_popped.size() == 17) chk("t6_last", 32'(m_popped[16]), 32'h55);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    clr_overflow = 1'b0;

    // Random traffic with occasional clears and asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 400) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
